// File: rtl/dom_thermostat_pipe.sv
// First-order DOM-masked thermostat controller, N_CH channels, 3-stage pipeline.
// Every secret travels as two Boolean shares (value = share0 ^ share1).
// Each masked AND is a DOM-indep gate whose cross terms are registered before
// they are ever combined with anything else.

// One channel of the masked datapath; share index is the [1:0] dimension.
module dom_thermo_lane #(
  parameter bit CLEAR_INVALID = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] ld_vld,     // valid bit being loaded into S1/S2/S3
  input  logic [1:0] too_cold,
  input  logic [1:0] too_hot,
  input  logic [1:0] mode,
  input  logic [1:0] fan_on,
  input  logic [3:0] rnd,        // {fan, fo, aircon, heater}
  output logic [1:0] heater,
  output logic [1:0] aircon,
  output logic [1:0] fan
);

  // S1: inner products and reshared cross products of heater/aircon ANDs
  typedef struct packed {
    logic [1:0] hq, hc, aq, ac, fon;
  } s1_t;

  // S2: heater/aircon shares plus the split pieces of fo = fan_on | heater
  typedef struct packed {
    logic [1:0] h, a, fl, fq, fc;
  } s2_t;

  // S3: outputs; fan kept split so its cross terms stay isolated in registers
  typedef struct packed {
    logic [1:0] h, a, gl, gq, gc;
  } s3_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;

  logic [1:0] ma, h, a, fo;

  // ~mode is applied to share 0 only, which inverts the unmasked value
  assign ma = {mode[1], ~mode[0]};

  // Stage 1 combinational: DOM-indep ANDs for heater and aircon
  always_comb begin
    s1_d     = '0;
    s1_d.hq  = mode & too_cold;
    s1_d.hc  = {(mode[1] & too_cold[0]) ^ rnd[0], (mode[0] & too_cold[1]) ^ rnd[0]};
    s1_d.aq  = ma & too_hot;
    s1_d.ac  = {(ma[1] & too_hot[0]) ^ rnd[1], (ma[0] & too_hot[1]) ^ rnd[1]};
    s1_d.fon = fan_on;
  end

  // Stage 2 combinational: collapse heater/aircon, start fo = fan_on | heater
  always_comb begin
    h     = s1_q.hq ^ s1_q.hc;
    a     = s1_q.aq ^ s1_q.ac;
    s2_d  = '0;
    s2_d.h  = h;
    s2_d.a  = a;
    s2_d.fl = s1_q.fon ^ h;
    s2_d.fq = s1_q.fon & h;
    s2_d.fc = {(s1_q.fon[1] & h[0]) ^ rnd[2], (s1_q.fon[0] & h[1]) ^ rnd[2]};
  end

  // Stage 3 combinational: fan = fo | aircon
  always_comb begin
    fo    = s2_q.fl ^ s2_q.fq ^ s2_q.fc;
    s3_d  = '0;
    s3_d.h  = s2_q.h;
    s3_d.a  = s2_q.a;
    s3_d.gl = fo ^ s2_q.a;
    s3_d.gq = fo & s2_q.a;
    s3_d.gc = {(fo[1] & s2_q.a[0]) ^ rnd[3], (fo[0] & s2_q.a[1]) ^ rnd[3]};
  end

  // Stage registers: load on en, bubbles load zero so no stale shares linger
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else if (en) begin
      s1_q <= (CLEAR_INVALID && !ld_vld[0]) ? '0 : s1_d;
      s2_q <= (CLEAR_INVALID && !ld_vld[1]) ? '0 : s2_d;
      s3_q <= (CLEAR_INVALID && !ld_vld[2]) ? '0 : s3_d;
    end
  end

  assign heater = s3_q.h;
  assign aircon = s3_q.a;
  assign fan    = s3_q.gl ^ s3_q.gq ^ s3_q.gc;

endmodule

module dom_thermostat_pipe #(
  parameter int N_CH          = 4,
  parameter bit CLEAR_INVALID = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_CH-1:0]   too_cold0,
  input  logic [N_CH-1:0]   too_cold1,
  input  logic [N_CH-1:0]   too_hot0,
  input  logic [N_CH-1:0]   too_hot1,
  input  logic [N_CH-1:0]   mode0,
  input  logic [N_CH-1:0]   mode1,
  input  logic [N_CH-1:0]   fan_on0,
  input  logic [N_CH-1:0]   fan_on1,
  input  logic [4*N_CH-1:0] rnd,
  input  logic              rnd_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_CH-1:0]   heater0,
  output logic [N_CH-1:0]   heater1,
  output logic [N_CH-1:0]   aircon0,
  output logic [N_CH-1:0]   aircon1,
  output logic [N_CH-1:0]   fan0,
  output logic [N_CH-1:0]   fan1
);

  localparam int STAGES = 3;

  logic                  en;
  logic [STAGES:1]       vld_pipe;
  logic [2:0]            ld_vld;
  logic [N_CH-1:0][1:0]  h_sh, a_sh, f_sh;

  // Whole pipe moves only with fresh randomness and room at the output
  assign en        = rnd_valid & (~out_valid | out_ready);
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];
  assign ld_vld    = {vld_pipe[2:1], in_valid};

  // Valid shift register; reset discards anything in flight
  always_ff @(posedge clk) begin
    if (!rst_n)  vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    dom_thermo_lane #(.CLEAR_INVALID(CLEAR_INVALID)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .ld_vld   (ld_vld),
      .too_cold ({too_cold1[i], too_cold0[i]}),
      .too_hot  ({too_hot1[i],  too_hot0[i]}),
      .mode     ({mode1[i],     mode0[i]}),
      .fan_on   ({fan_on1[i],   fan_on0[i]}),
      .rnd      ({rnd[3*N_CH+i], rnd[2*N_CH+i], rnd[N_CH+i], rnd[i]}),
      .heater   (h_sh[i]),
      .aircon   (a_sh[i]),
      .fan      (f_sh[i])
    );
    assign heater0[i] = h_sh[i][0];
    assign heater1[i] = h_sh[i][1];
    assign aircon0[i] = a_sh[i][0];
    assign aircon1[i] = a_sh[i][1];
    assign fan0[i]    = f_sh[i][0];
    assign fan1[i]    = f_sh[i][1];
  end

endmodule

// File: tb/tb_dom_thermostat_pipe.sv
// Directed bench for dom_thermostat_pipe: vector table plus stall/backpressure/reset sequences.
module tb_dom_thermostat_pipe;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, rnd_valid, out_valid, out_ready;
  logic [N-1:0] too_cold0, too_cold1, too_hot0, too_hot1, mode0, mode1, fan_on0, fan_on1;
  logic [4*N-1:0] rnd;
  logic [N-1:0] heater0, heater1, aircon0, aircon1, fan0, fan1;

  dom_thermostat_pipe #(.N_CH(N), .CLEAR_INVALID(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .too_cold0(too_cold0), .too_cold1(too_cold1), .too_hot0(too_hot0), .too_hot1(too_hot1),
    .mode0(mode0), .mode1(mode1), .fan_on0(fan_on0), .fan_on1(fan_on1),
    .rnd(rnd), .rnd_valid(rnd_valid), .out_valid(out_valid), .out_ready(out_ready),
    .heater0(heater0), .heater1(heater1), .aircon0(aircon0), .aircon1(aircon1),
    .fan0(fan0), .fan1(fan1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] mode, cold, hot, fon;
    logic [N-1:0] eh, ea, ef;
  } vec_t;

  vec_t tbl[8];
  int n_vec = 0, n_err = 0, n_deliv = 0;
  logic [N-1:0] exp_h, exp_a, exp_f;
  logic [3*N-1:0] sb[$];
  logic [6*N-1:0] raws[$];
  logic [6*N-1:0] held;
  logic held_v;

  wire [6*N-1:0] raw = {heater0, heater1, aircon0, aircon1, fan0, fan1};

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Fresh randomness every cycle, whether or not it is marked valid
  initial begin
    rnd = '0;
    forever begin
      @(posedge clk);
      #1 rnd = $urandom;
    end
  end

  // Scoreboard: record accepted beats, compare unmasked outputs on delivery
  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else begin
      if (out_valid && out_ready && rnd_valid) begin
        if (sb.size() == 0) chk("unexpected_out", {31'd0, out_valid}, 32'd0);
        else begin
          logic [3*N-1:0] e;
          e = sb.pop_front();
          chk("heater", {28'd0, heater0 ^ heater1}, {28'd0, e[3*N-1:2*N]});
          chk("aircon", {28'd0, aircon0 ^ aircon1}, {28'd0, e[2*N-1:N]});
          chk("fan",    {28'd0, fan0 ^ fan1},       {28'd0, e[N-1:0]});
          n_deliv++;
        end
      end
      if (in_valid && rnd_valid && (!out_valid || out_ready)) sb.push_back({exp_h, exp_a, exp_f});
    end
  end

  task automatic set_beat(input vec_t v);
    logic [N-1:0] r;
    r = $urandom; mode0 = r; mode1 = v.mode ^ r;
    r = $urandom; too_cold0 = r; too_cold1 = v.cold ^ r;
    r = $urandom; too_hot0 = r; too_hot1 = v.hot ^ r;
    r = $urandom; fan_on0 = r; fan_on1 = v.fon ^ r;
    exp_h = v.eh; exp_a = v.ea; exp_f = v.ef;
    in_valid = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic latency_check(input vec_t v);
    set_beat(v);
    tick(1); in_valid = 1'b0;
    chk("lat_c1", {31'd0, out_valid}, 32'd0);
    tick(1);
    chk("lat_c2", {31'd0, out_valid}, 32'd0);
    tick(1);
    chk("lat_c3", {31'd0, out_valid}, 32'd1);
    tick(2);
  endtask

  task automatic wait_out_valid(input string nm);
    int k;
    k = 0;
    while (!out_valid && k < 20) begin tick(1); k++; end
    chk(nm, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    tbl[0] = '{4'b0011, 4'b0101, 4'b1010, 4'b0000, 4'b0001, 4'b1000, 4'b1001};
    tbl[1] = '{4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0110};
    tbl[2] = '{4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111};
    tbl[3] = '{4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111};
    tbl[4] = '{4'b1010, 4'b1100, 4'b0110, 4'b0001, 4'b1000, 4'b0100, 4'b1101};
    tbl[5] = '{4'b0101, 4'b0011, 4'b1001, 4'b1000, 4'b0001, 4'b1000, 4'b1001};
    tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[7] = '{4'b1100, 4'b1010, 4'b0101, 4'b0011, 4'b1000, 4'b0001, 4'b1011};

    rst_n = 1'b0; in_valid = 1'b0; rnd_valid = 1'b1; out_ready = 1'b1;
    mode0 = '0; mode1 = '0; too_cold0 = '0; too_cold1 = '0;
    too_hot0 = '0; too_hot1 = '0; fan_on0 = '0; fan_on1 = '0;
    exp_h = '0; exp_a = '0; exp_f = '0;
    tick(2);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_shares", {8'd0, raw}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick(1);

    // Single beat latency
    latency_check(tbl[0]);

    // Same beat five times, fresh splits and randomness each time
    for (int i = 0; i < 9; i++) begin
      if (i < 5) set_beat(tbl[0]); else in_valid = 1'b0;
      tick(1);
      if (out_valid) raws.push_back(raw);
    end
    chk("repeat_count", raws.size(), 32'd5);
    for (int k = 1; k < raws.size(); k++)
      chk("repeat_shares_differ", {31'd0, raws[k] != raws[k-1]}, 32'd1);
    tick(2);

    // Whole table back-to-back
    for (int j = 0; j < 8; j++) begin set_beat(tbl[j]); tick(1); end
    in_valid = 1'b0;
    tick(5);

    // Randomness starvation mid-stream
    for (int j = 2; j < 8; j++) begin
      set_beat(tbl[j]);
      if (j == 5) begin
        rnd_valid = 1'b0;
        #1;
        held = raw; held_v = out_valid;
        for (int c = 0; c < 4; c++) begin
          chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
          tick(1);
          chk("stall_out_valid", {31'd0, out_valid}, {31'd0, held_v});
          chk("stall_shares", {8'd0, raw}, {8'd0, held});
        end
        rnd_valid = 1'b1;
      end
      tick(1);
    end
    in_valid = 1'b0;
    tick(5);

    // Backpressure while an output is pending
    for (int j = 2; j < 5; j++) begin set_beat(tbl[j]); tick(1); end
    in_valid = 1'b0;
    wait_out_valid("bp_wait");
    out_ready = 1'b0;
    #1;
    held = raw;
    for (int c = 0; c < 3; c++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick(1);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_shares", {8'd0, raw}, {8'd0, held});
    end
    out_ready = 1'b1;
    tick(6);

    // Reset with three beats in flight
    for (int j = 5; j < 8; j++) begin set_beat(tbl[j]); tick(1); end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick(1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_shares", {8'd0, raw}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    latency_check(tbl[4]);
    tick(4);

    chk("deliveries", n_deliv, 32'd24);
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
